param_ctrl_n: RTL and testbench
===============================

PARAM_CTRL_N -- requirements
Module: param_ctrl_n

Interface
REQ-001 SHALL have parameter NUM_PARAM, default 5: number of controlled parameters, 1..8.
REQ-002 SHALL have parameter PW, default 11: bit width of each parameter value.
REQ-003 SHALL have parameter P_MIN, default {11'd2,11'd10,11'd1,11'd1,11'd1}: packed per-parameter minimum, index 0 in LSBs.
REQ-004 SHALL have parameter P_MAX, default {11'd20,11'd800,11'd300,11'd4,11'd6}: packed per-parameter maximum.
REQ-005 SHALL have parameter P_STEP, default {11'd1,11'd10,11'd1,11'd1,11'd1}: packed per-parameter step, nonzero.
REQ-006 SHALL have parameter P_INIT, default {11'd2,11'd10,11'd1,11'd1,11'd1}: packed reset values, each within [min,max].
REQ-007 SHALL have parameter WRAP_MASK, default 5'b01111: bit i=1 means parameter i wraps, 0 means it saturates.
REQ-008 SHALL have parameter HOLD_CYC, default 25_000_000: key hold time before auto-repeat starts.
REQ-009 SHALL have parameter RPT_CYC, default 5_000_000: auto-repeat period.
REQ-010 SHALL have port clk, input, 1: 50 MHz clock.
REQ-011 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-012 SHALL have port key_sel, input, 1: debounced synchronous level, high when pressed; advances the cursor.
REQ-013 SHALL have port key_inc, input, 1: debounced level; increments the selected parameter.
REQ-014 SHALL have port key_dec, input, 1: debounced level; decrements the selected parameter.
REQ-015 SHALL have port par_val, output, NUM_PARAM*PW: packed registered parameter values.
REQ-016 SHALL have port sel, output, 3: index of the currently selected parameter.
REQ-017 SHALL have port disp_data, output, 20: value of the selected parameter, zero-extended.
REQ-018 SHALL have port upd, output, 1: one-cycle pulse when any parameter value changes.
REQ-019 SHALL have port at_limit, output, 1: high while the selected value equals its min or its max.

Function
REQ-020 SHALL register each key and detect a rising edge as (key high) and (registered key low).
REQ-021 SHALL advance sel by 1 on a key_sel edge and wrap from NUM_PARAM-1 to 0.
REQ-022 SHALL raise an inc or dec event on the key edge; par_val SHALL update at the next clock edge, one cycle of latency.
REQ-023 SHALL start a hold counter on the edge; after HOLD_CYC cycles of continuous high, SHALL raise one event, then one event every RPT_CYC cycles until release.
REQ-024 SHALL clear the hold and repeat counters when the key is released.
REQ-025 SHALL treat inc and dec both high as no event, clear both counters, and require a fresh edge after either key is released.
REQ-026 SHALL, on a key_sel edge, cancel any active hold or repeat; auto-repeat SHALL resume only after a new inc/dec edge.
REQ-027 SHALL let an inc/dec event in the same cycle as a key_sel edge apply to the old sel.
REQ-028 SHALL compute inc as val+step in PW+1 bits; if the result exceeds max, the value becomes min when wrap is set, max otherwise.
REQ-029 SHALL apply dec when val >= min+step (PW+1 bits) to give val-step; otherwise the value becomes max when wrap is set, min otherwise.
REQ-030 SHALL leave unselected parameters unchanged.
REQ-031 SHALL assert upd only when the new value differs from the old, so a saturate event at the limit gives no pulse.
REQ-032 SHALL register disp_data and at_limit from the selected value, one cycle after par_val or sel changes.

Reset
REQ-033 SHALL, while reset_n is low, asynchronously set par_val=P_INIT, sel=0, disp_data=P_INIT[0] zero-extended, upd=0, at_limit=1 (default), all key registers and counters to 0.
REQ-034 SHALL start normal operation at the first clk edge after reset_n deasserts; a key already high at that point SHALL count as an edge.
REQ-035 SHALL abandon any in-progress hold or repeat and restore all state to reset values on reset mid-operation.

Verification (HOLD_CYC=20, RPT_CYC=5 in bench)
REQ-036 SHALL verify reset followed by key_sel pressed 2 times and key_inc pressed 1 time -> sel=2, param2 changes 1 to 2, upd pulses once, disp_data=2.
REQ-037 SHALL verify param3 at 800 with key_inc pressed 1 time -> param3=10 (wrap) and at_limit=1.
REQ-038 SHALL verify param4 at 20 with key_inc pressed -> param4 stays 20 with no upd; at 2 with key_dec pressed -> param4 stays 2 with no upd.
REQ-039 SHALL verify key_inc held 36 cycles on param0 starting at 1 -> edge then repeats at hold cycles 20, 25, 30, 35, so param0=6 (5 events).
REQ-040 SHALL verify inc and dec both held for 40 cycles -> no change; dec released, then inc held on -> still no change until inc gets a new edge.
REQ-041 SHALL verify reset_n pulsed low during an auto-repeat -> par_val returns to P_INIT immediately, with no events until a new edge.

Source files
------------

// File: rtl/param_ctrl_n.sv
// Key-driven parameter editor: a cursor selects one of NUM_PARAM values, inc/dec keys
// step it with wrap or saturate per parameter, and auto-repeat takes over on a long hold.
module param_ctrl_n #(
    parameter int NUM_PARAM = 5,
    parameter int PW = 11,
    parameter logic [NUM_PARAM*PW-1:0] P_MIN  = {11'd2, 11'd10, 11'd1, 11'd1, 11'd1},
    parameter logic [NUM_PARAM*PW-1:0] P_MAX  = {11'd20, 11'd800, 11'd300, 11'd4, 11'd6},
    parameter logic [NUM_PARAM*PW-1:0] P_STEP = {11'd1, 11'd10, 11'd1, 11'd1, 11'd1},
    parameter logic [NUM_PARAM*PW-1:0] P_INIT = {11'd2, 11'd10, 11'd1, 11'd1, 11'd1},
    parameter logic [NUM_PARAM-1:0] WRAP_MASK = 5'b01111,
    parameter int HOLD_CYC = 25_000_000,
    parameter int RPT_CYC = 5_000_000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    key_sel,
    input  logic                    key_inc,
    input  logic                    key_dec,
    output logic [NUM_PARAM*PW-1:0] par_val,
    output logic [2:0]              sel,
    output logic [19:0]             disp_data,
    output logic                    upd,
    output logic                    at_limit
);

    // state  | meaning
    // S_IDLE | no auto-repeat armed; only a fresh inc/dec edge produces an event
    // S_HOLD | key held since its edge, timer counting down to the first repeat
    // S_RPT  | auto-repeating, timer counting down to the next repeat
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RPT} state_t;

    localparam int TMAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
    localparam int TW = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);
    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] RPT_LD = TW'(RPT_CYC - 1);
    localparam logic INIT_LIM = (P_INIT[PW-1:0] == P_MIN[PW-1:0]) ||
                                (P_INIT[PW-1:0] == P_MAX[PW-1:0]);

    state_t        state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic          dir, dir_nxt;
    logic          inc_q, dec_q, sel_q;
    logic          inc_edge, dec_edge, sel_edge, both;
    logic          ev_inc, ev_dec;
    logic [2:0]    sel_r;
    logic [PW-1:0] val_r [NUM_PARAM];
    logic [PW-1:0] cur, mn, mx, stp, nxt;
    logic [PW:0]   sum, lim;
    logic          wrp, chg;

    assign inc_edge = key_inc & ~inc_q;
    assign dec_edge = key_dec & ~dec_q;
    assign sel_edge = key_sel & ~sel_q;
    assign both     = key_inc & key_dec;

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        dir_nxt   = dir;
        ev_inc    = 1'b0;
        ev_dec    = 1'b0;
        if (both) begin
            state_nxt = S_IDLE;
            tmr_nxt   = '0;
        end else if (inc_edge || dec_edge) begin
            ev_inc    = inc_edge;
            ev_dec    = dec_edge;
            dir_nxt   = inc_edge;
            state_nxt = S_HOLD;
            tmr_nxt   = HOLD_LD;
        end else if (sel_edge) begin
            state_nxt = S_IDLE;
            tmr_nxt   = '0;
        end else if (state != S_IDLE) begin
            if (!(dir ? key_inc : key_dec)) begin
                state_nxt = S_IDLE;
                tmr_nxt   = '0;
            end else if (tmr == '0) begin
                ev_inc    = dir;
                ev_dec    = ~dir;
                state_nxt = S_RPT;
                tmr_nxt   = RPT_LD;
            end else begin
                tmr_nxt = tmr - 1'b1;
            end
        end
    end

    always_comb begin
        cur = '0;
        mn  = '0;
        mx  = '0;
        stp = '0;
        wrp = 1'b0;
        for (int i = 0; i < NUM_PARAM; i++) begin
            if (sel_r == 3'(i)) begin
                cur = val_r[i];
                mn  = P_MIN[i*PW +: PW];
                mx  = P_MAX[i*PW +: PW];
                stp = P_STEP[i*PW +: PW];
                wrp = WRAP_MASK[i];
            end
        end
        sum = {1'b0, cur} + {1'b0, stp};
        lim = {1'b0, mn} + {1'b0, stp};
        nxt = cur;
        if (ev_inc) begin
            nxt = (sum > {1'b0, mx}) ? (wrp ? mn : mx) : sum[PW-1:0];
        end else if (ev_dec) begin
            nxt = ({1'b0, cur} >= lim) ? (cur - stp) : (wrp ? mx : mn);
        end
        chg = (ev_inc | ev_dec) && (nxt != cur);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            tmr       <= '0;
            dir       <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            sel_q     <= 1'b0;
            sel_r     <= '0;
            upd       <= 1'b0;
            disp_data <= 20'(P_INIT[PW-1:0]);
            at_limit  <= INIT_LIM;
            for (int i = 0; i < NUM_PARAM; i++) val_r[i] <= P_INIT[i*PW +: PW];
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            dir   <= dir_nxt;
            inc_q <= key_inc;
            dec_q <= key_dec;
            sel_q <= key_sel;
            // the value update uses sel_r before the cursor moves in the same cycle
            if (sel_edge) sel_r <= (sel_r == 3'(NUM_PARAM - 1)) ? 3'd0 : sel_r + 3'd1;
            for (int i = 0; i < NUM_PARAM; i++) begin
                if (chg && sel_r == 3'(i)) val_r[i] <= nxt;
            end
            upd       <= chg;
            disp_data <= 20'(cur);
            at_limit  <= (cur == mn) || (cur == mx);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PARAM; g++) begin : g_pack
            assign par_val[g*PW +: PW] = val_r[g];
        end
    endgenerate

    assign sel = sel_r;

endmodule

// File: tb/tb_param_ctrl_n.sv
// Bench for param_ctrl_n: stimulus pushes expected par_val snapshots into a queue and
// a monitor pops one on every upd pulse.
module tb_param_ctrl_n;
    localparam int NP = 5;
    localparam int PW = 11;
    localparam logic [NP*PW-1:0] INIT = {11'd2, 11'd10, 11'd1, 11'd1, 11'd1};

    logic clk, reset_n, key_sel, key_inc, key_dec;
    logic [NP*PW-1:0] par_val;
    logic [2:0] sel;
    logic [19:0] disp_data;
    logic upd, at_limit;

    logic [NP*PW-1:0] exp_pv;
    logic [NP*PW-1:0] q[$];
    int n_cmp = 0;
    int n_bad = 0;

    param_ctrl_n #(.HOLD_CYC(20), .RPT_CYC(5)) dut (
        .clk(clk), .reset_n(reset_n), .key_sel(key_sel), .key_inc(key_inc),
        .key_dec(key_dec), .par_val(par_val), .sel(sel), .disp_data(disp_data),
        .upd(upd), .at_limit(at_limit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    task automatic push_val(input int idx, input int v);
        exp_pv[idx*PW +: PW] = PW'(v);
        q.push_back(exp_pv);
    endtask

    task automatic drive(input logic s, input logic i, input logic d, input int n);
        @(negedge clk);
        key_sel = s; key_inc = i; key_dec = d;
        repeat (n) @(negedge clk);
        key_sel = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
    endtask

    task automatic settle_and_drain(input string name);
        repeat (3) @(negedge clk);
        chk({name, "_drain"}, 64'(q.size()), 64'd0);
        q.delete();
    endtask

    // monitor: every upd must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset_n && upd) begin
            if (q.size() == 0) begin
                chk("unexp_upd", 64'(par_val), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("upd_val", 64'(par_val), 64'(q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        key_sel = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
        reset_n = 1'b0;
        exp_pv = INIT;
        #12;
        chk("rst_par", 64'(par_val), 64'(INIT));
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_disp", 64'(disp_data), 64'd1);
        chk("rst_upd", 64'(upd), 64'd0);
        chk("rst_lim", 64'(at_limit), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // cursor to 2, one increment of param2 (1 -> 2)
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 1);
        push_val(2, 2);
        drive(0, 1, 0, 1);
        settle_and_drain("p2_inc");
        chk("p2_sel", 64'(sel), 64'd2);
        chk("p2_disp", 64'(disp_data), 64'd2);
        chk("p2_lim", 64'(at_limit), 64'd0);

        // param3: walk 10 -> 800 then wrap back to 10
        drive(1, 0, 0, 1);
        for (int i = 1; i <= 79; i++) begin
            push_val(3, 10 + 10 * i);
            drive(0, 1, 0, 1);
        end
        settle_and_drain("p3_up");
        chk("p3_lim_max", 64'(at_limit), 64'd1);
        push_val(3, 10);
        drive(0, 1, 0, 1);
        settle_and_drain("p3_wrap");
        chk("p3_disp", 64'(disp_data), 64'd10);
        chk("p3_lim_min", 64'(at_limit), 64'd1);

        // param4 saturates at both ends without upd
        drive(1, 0, 0, 1);
        drive(0, 0, 1, 1);
        settle_and_drain("p4_dec_min");
        chk("p4_at_min", 64'(par_val[4*PW +: PW]), 64'd2);
        for (int v = 3; v <= 20; v++) begin
            push_val(4, v);
            drive(0, 1, 0, 1);
        end
        drive(0, 1, 0, 1);
        settle_and_drain("p4_inc_max");
        chk("p4_at_max", 64'(par_val[4*PW +: PW]), 64'd20);
        chk("p4_lim", 64'(at_limit), 64'd1);

        // cursor wraps 4 -> 0; 36-cycle hold gives edge + repeats at 20,25,30,35
        drive(1, 0, 0, 1);
        for (int v = 2; v <= 6; v++) push_val(0, v);
        drive(0, 1, 0, 36);
        settle_and_drain("p0_hold");
        chk("p0_sel", 64'(sel), 64'd0);
        chk("p0_val", 64'(par_val[0 +: PW]), 64'd6);

        // param1: inc+dec together, then dec released with inc still held
        drive(1, 0, 0, 1);
        @(negedge clk);
        key_inc = 1'b1; key_dec = 1'b1;
        repeat (40) @(negedge clk);
        key_dec = 1'b0;
        repeat (30) @(negedge clk);
        key_inc = 1'b0;
        settle_and_drain("p1_both");
        chk("p1_unchanged", 64'(par_val[1*PW +: PW]), 64'd1);
        push_val(1, 2);
        drive(0, 1, 0, 1);
        settle_and_drain("p1_fresh");

        // auto-repeat on param1 (2 -> 3 -> 4 -> wrap 1), reset during repeat
        push_val(1, 3);
        push_val(1, 4);
        push_val(1, 1);
        @(negedge clk);
        key_inc = 1'b1;
        repeat (28) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_par", 64'(par_val), 64'(INIT));
        chk("mid_rst_sel", 64'(sel), 64'd0);
        chk("mid_rst_q", 64'(q.size()), 64'd0);
        key_inc = 1'b0;
        exp_pv = INIT;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_par", 64'(par_val), 64'(INIT));

        // inc event in the same cycle as a sel edge lands on the old cursor
        push_val(0, 2);
        drive(1, 1, 0, 1);
        settle_and_drain("same_cyc");
        chk("same_cyc_sel", 64'(sel), 64'd1);

        // sel edge during a hold cancels the pending auto-repeat
        push_val(1, 2);
        @(negedge clk);
        key_inc = 1'b1;
        repeat (10) @(negedge clk);
        key_sel = 1'b1;
        @(negedge clk);
        key_sel = 1'b0;
        repeat (30) @(negedge clk);
        key_inc = 1'b0;
        settle_and_drain("sel_cancel");
        chk("cancel_p1", 64'(par_val[1*PW +: PW]), 64'd2);
        chk("cancel_sel", 64'(sel), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
